// File: rtl/monitor_trace_sampler.sv
// -----------------------------------------------------------------------------
// monitor_trace_sampler
//
// Change-based trace capture. After a start pulse, the block writes one entry
// {timestamp, probes} for the initial probe value and then one more entry
// each time the registered probe vector differs from the last value it
// stored. Capture ends on a stop pulse or when the trace memory is full. The
// memory itself is external; this block only drives its write port.
//
// Ports
//   ACLK      : clock, rising edge
//   ARESETN   : asynchronous active-low reset
//   start     : one-cycle pulse, begins a capture (ignored while capturing)
//   stop      : one-cycle pulse, ends a capture
//   probes    : monitored signals, synchronous to ACLK
//   mem_we    : trace-memory write strobe, one cycle per entry
//   mem_addr  : trace-memory write address (holds when mem_we is low)
//   mem_din   : write data {timestamp, probes} (holds when mem_we is low)
//   busy      : capture running (state RUN)
//   done      : capture finished (state DONE)
//   count     : entries written in the current or last capture
//   full      : last capture ended because the memory filled
// -----------------------------------------------------------------------------
module monitor_trace_sampler #(
   parameter int PROBE_WIDTH = 32,
   parameter int TS_WIDTH    = 32,
   parameter int ADDR_WIDTH  = 10
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic                            start,
   input  logic                            stop,
   input  logic [PROBE_WIDTH-1:0]          probes,
   output logic                            mem_we,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic [TS_WIDTH+PROBE_WIDTH-1:0] mem_din,
   output logic                            busy,
   output logic                            done,
   output logic [ADDR_WIDTH:0]             count,
   output logic                            full
);

   localparam int DIN_WIDTH = TS_WIDTH + PROBE_WIDTH;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FIRST = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // A write made while count holds this value fills the memory.
   localparam logic [ADDR_WIDTH:0] LAST_COUNT = {1'b0, {ADDR_WIDTH{1'b1}}};

   logic [1:0]             state_q, state_d;
   logic [TS_WIDTH-1:0]    ts_q, ts_d;
   logic [ADDR_WIDTH:0]    count_q, count_d;
   logic                   full_q, full_d;
   logic [PROBE_WIDTH-1:0] p_q;
   logic [PROBE_WIDTH-1:0] p_last_q, p_last_d;
   logic                   we_q, we_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DIN_WIDTH-1:0]   din_q, din_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d  = state_q;
      ts_d     = ts_q;
      count_d  = count_q;
      full_d   = full_q;
      p_last_d = p_last_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_FIRST;
               ts_d    = '0;
               count_d = '0;
               full_d  = 1'b0;
            end
         end

         ST_FIRST: begin
            // The initial sample is always recorded, even if stop arrives now.
            we_d     = 1'b1;
            addr_d   = '0;
            din_d    = {ts_q, p_q};
            p_last_d = p_q;
            count_d  = (ADDR_WIDTH+1)'(1);
            ts_d     = ts_q + TS_WIDTH'(1);
            state_d  = stop ? ST_DONE : ST_RUN;
         end

         ST_RUN: begin
            // Timestamp wraps silently at 2^TS_WIDTH.
            ts_d = ts_q + TS_WIDTH'(1);
            if (stop) begin
               // Stop wins over a probe change on the same edge.
               state_d = ST_DONE;
            end else if (p_q != p_last_q) begin
               we_d     = 1'b1;
               addr_d   = count_q[ADDR_WIDTH-1:0];
               din_d    = {ts_q, p_q};
               p_last_d = p_q;
               count_d  = count_q + (ADDR_WIDTH+1)'(1);
               if (count_q == LAST_COUNT) begin
                  full_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Status flags track the state being entered so they are registered
      // alongside it rather than decoded from it.
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q  <= ST_IDLE;
         ts_q     <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         p_q      <= '0;
         p_last_q <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q  <= state_d;
         ts_q     <= ts_d;
         count_q  <= count_d;
         full_q   <= full_d;
         p_q      <= probes;
         p_last_q <= p_last_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign mem_we   = we_q;
   assign mem_addr = addr_q;
   assign mem_din  = din_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign count    = count_q;
   assign full     = full_q;

endmodule
